mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port 32x8 memory (clk/addr/data_in/read/write/data_out) among NREQ requesters.
//  Round-robin arbitration, one access in flight at a time, read data returned with requester ID.
//  Sits between requester blocks and the mem instance in mem_top.
//  Replaces direct tester drive of the memory pins.
// PARAMETERS
//  NREQ    2  number of requesters (>=2)
//  ADDR_W  5  memory address width
//  DATA_W  8  memory data width
//  RD_LAT  1  cycles from the edge sampling mem_read to data_out valid (>=1)
// PORTS
//  clk          in   1              single clock, all logic on posedge
//  reset        in   1              synchronous, active-high
//  req          in   NREQ           request per requester, level
//  req_write    in   NREQ           1=write, 0=read, per requester
//  req_addr     in   NREQ*ADDR_W    address per requester (unpacked array)
//  req_wdata    in   NREQ*DATA_W    write data per requester (unpacked array)
//  gnt          out  NREQ           one-hot, 1-cycle pulse: request accepted
//  rsp_valid    out  1              1-cycle pulse: read data valid
//  rsp_id       out  $clog2(NREQ)   requester owning rsp_rdata
//  rsp_rdata    out  DATA_W         read data
//  busy         out  1              1 whenever state != IDLE
//  mem_addr     out  ADDR_W         to mem addr
//  mem_data_in  out  DATA_W         to mem data_in
//  mem_read     out  1              to mem read
//  mem_write    out  1              to mem write
//  mem_data_out in   DATA_W         from mem data_out
// BEHAVIOUR
//  - All outputs registered. Reset: every output 0, state IDLE, rr pointer = NREQ-1 (req 0 wins first).
//  - FSM: IDLE -> ISSUE -> (write) IDLE | (read) RDWAIT -> IDLE.
//  - IDLE, cycle T, any req high:
//    - pick winner i = first set bit searching from ptr+1 upward with wraparound.
//    - at edge end-of-T: gnt[i]=1; mem_addr/mem_data_in latched from requester i.
//    - at the same edge: mem_write=req_write[i], mem_read=!req_write[i]; ptr=i; go ISSUE.
//  - ISSUE (cycle T+1): gnt and the strobe are high for exactly this one cycle.
//    - next edge clears them.
//    - write -> IDLE in T+2.
//    - read -> RDWAIT, cnt=RD_LAT-1.
//  - RDWAIT: when cnt==0, capture mem_data_out into rsp_rdata, set rsp_id=i, pulse rsp_valid, go IDLE.
//    - otherwise cnt--.
//    - RD_LAT=1: rsp_valid high in T+3.
//  - Throughput: write 2 cycles/access, read 2+RD_LAT. IDLE may accept a new req in the same cycle rsp_valid is high.
//  - req is sampled only in IDLE. Requester holds req/fields stable until gnt, then drops or updates req on the edge ending the gnt cycle.
//  - req dropped before grant: no access, no error.
//  - Simultaneous reqs: round-robin only. Starvation-free: each waiting requester is served within NREQ grants.
//  - mem_read & mem_write never both 1. gnt is onehot0. rsp_valid never without a prior read grant.
//  - Address is used as-is: ADDR_W bits, no wrap logic needed (31 is a legal top address).
//  - Reset mid-operation (ISSUE/RDWAIT): aborts. No rsp_valid. Strobes 0 after the reset edge. ptr reinitialised.
// STRUCTURE
//  - Package mem_arb_pkg:
//    - typedef enum logic[1:0] {IDLE, ISSUE, RDWAIT} arb_state_t
//    - default ADDR_W/DATA_W localparams
//  - Sub-module rr_arbiter #(NREQ): combinational.
//    - inputs: req vector and ptr.
//    - outputs: one-hot win vector, win index, any.
//  - Top holds FSM, latch registers, RD_LAT counter, response registers.
// TESTING
//  1. After reset: req[0] write addr 5'h03 data 8'hA5 -> gnt[0] and mem_write, addr 03, data A5, all high for one cycle in T+1.
//     Then req[1] read addr 03 -> rsp_valid in T+3 with rsp_id=1, rsp_rdata=8'hA5.
//  2. req[0] and req[1] both held high doing reads after reset -> grant order 0,1,0,1; each rsp_id matches its grant.
//  3. Write 8'hFF to addr 5'h1F and 8'h00 to addr 5'h00 -> read-back returns FF and 00 respectively.
//  4. reset asserted during RDWAIT -> rsp_valid stays 0, all outputs 0 next cycle.
//     Next simultaneous req[0]/req[1] -> gnt[0] first.
//  5. req[1] write asserted while busy with req[0] read -> no gnt[1] until IDLE.
//     Back-to-back writes take exactly 2 cycles each.
//  6. Assertions over random traffic, 1000 cycles:
//     - !(mem_read && mem_write)
//     - $onehot0(gnt)
//     - busy == (state != IDLE)

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter slice.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RDWAIT
    } arb_state_t;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Round-robin pick: first set request after ptr_i, wrapping around.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] win_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    int j;

    always_comb begin
        win_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                idx_o    = IW'(j);
                win_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NREQ requesters,
// one access in flight, read data tagged with the owning requester.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1,
    parameter int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_write,
    input  logic [ADDR_W-1:0] req_addr  [NREQ],
    input  logic [DATA_W-1:0] req_wdata [NREQ],
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_valid,
    output logic [IW-1:0]     rsp_id,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    arb_state_t        state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     own_q;
    logic [CW-1:0]     cnt_q;
    logic [NREQ-1:0]   gnt_q;
    logic              rsp_valid_q;
    logic [IW-1:0]     rsp_id_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              busy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_q;
    logic              wr_q;

    logic [NREQ-1:0]   win_d;
    logic [IW-1:0]     idx_d;
    logic              any_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (win_d),
        .idx_o (idx_d),
        .any_o (any_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= IW'(NREQ - 1);
            own_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
        end else begin
            // Grant, strobes and response are single-cycle pulses.
            gnt_q       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_d) begin
                        gnt_q   <= win_d;
                        addr_q  <= req_addr[idx_d];
                        wdata_q <= req_wdata[idx_d];
                        wr_q    <= req_write[idx_d];
                        rd_q    <= !req_write[idx_d];
                        ptr_q   <= idx_d;
                        own_q   <= idx_d;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wr_q) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= CW'(RD_LAT - 1);
                        state_q <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    if (cnt_q == '0) begin
                        rsp_rdata_q <= mem_data_out;
                        rsp_id_q    <= own_q;
                        rsp_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign busy        = busy_q;
    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign mem_read    = rd_q;
    assign mem_write   = wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 32x8 memory.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int RDL  = 1;
    localparam int QD   = 1024;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] req_write;
    logic [AW-1:0]   req_addr  [NREQ];
    logic [DW-1:0]   req_wdata [NREQ];
    logic [NREQ-1:0] gnt;
    logic            rsp_valid;
    logic [0:0]      rsp_id;
    logic [DW-1:0]   rsp_rdata;
    logic            busy;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data_in;
    logic            mem_read;
    logic            mem_write;
    logic [DW-1:0]   mem_data_out = '0;

    mem_arbiter #(
        .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDL)
    ) dut (
        .clk(clk), .reset(reset),
        .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .busy(busy), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_read(mem_read),
        .mem_write(mem_write), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    logic [DW-1:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_data_in;
        if (mem_read) mem_data_out <= mem[mem_addr];
    end

    // Per-requester op queues, filled by the test, consumed by drivers
    logic          ops_wr [NREQ][QD];
    logic [AW-1:0] ops_a  [NREQ][QD];
    logic [DW-1:0] ops_d  [NREQ][QD];
    int            head [NREQ];
    int            tail [NREQ];
    logic          pend [NREQ];
    logic          drv_req [NREQ];

    initial for (int i = 0; i < NREQ; i++) begin
        head[i] = 0;
        tail[i] = 0;
    end

    for (genvar g = 0; g < NREQ; g++) begin : drv
        assign req[g] = drv_req[g];
        always begin
            @(posedge clk);
            #1;
            if (reset) begin
                head[g] = tail[g];
                pend[g] = 1'b0;
                drv_req[g] = 1'b0;
                req_write[g] = 1'b0;
                req_addr[g] = '0;
                req_wdata[g] = '0;
            end else begin
                if (pend[g]) begin
                    head[g]++;
                    pend[g] = 1'b0;
                end
                if (gnt[g]) begin
                    pend[g] = 1'b1;
                end else if (head[g] != tail[g]) begin
                    drv_req[g]   = 1'b1;
                    req_write[g] = ops_wr[g][head[g]];
                    req_addr[g]  = ops_a[g][head[g]];
                    req_wdata[g] = ops_d[g][head[g]];
                end else begin
                    drv_req[g] = 1'b0;
                end
            end
        end
    end

    task automatic push_op(input int id, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        ops_wr[id][tail[id]] = wr;
        ops_a[id][tail[id]]  = a;
        ops_d[id][tail[id]]  = d;
        tail[id]++;
    endtask

    typedef struct {
        int          id;
        logic [DW-1:0] d;
        int          gc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    logic [DW-1:0] shadow [32];
    int            glog_id[$];
    int            glog_cyc[$];
    logic [DW-1:0] rlog[$];
    logic          prev_busy = 1'b0;
    int            gid;

    initial for (int i = 0; i < 32; i++) shadow[i] = '0;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            chk("rw_excl", 32'(mem_read && mem_write), 0);
            chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
            chk("busy_state", 32'(busy), 32'(dut.state_q != IDLE));
            chk("strobe_gnt", 32'(mem_read | mem_write), 32'(|gnt));
            if (|gnt) begin
                gid = gnt[1] ? 1 : 0;
                chk("gnt_after_idle", 32'(prev_busy), 0);
                chk("mem_addr", 32'(mem_addr), 32'(ops_a[gid][head[gid]]));
                chk("mem_write", 32'(mem_write), 32'(ops_wr[gid][head[gid]]));
                if (ops_wr[gid][head[gid]]) begin
                    chk("mem_wdata", 32'(mem_data_in), 32'(ops_d[gid][head[gid]]));
                    shadow[ops_a[gid][head[gid]]] = ops_d[gid][head[gid]];
                end else begin
                    exp_q.push_back('{gid, shadow[ops_a[gid][head[gid]]], cyc});
                end
                glog_id.push_back(gid);
                glog_cyc.push_back(cyc);
            end
            if (rsp_valid) begin
                rlog.push_back(rsp_rdata);
                if (exp_q.size() == 0) begin
                    chk("rsp_spurious", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.d));
                    chk("rsp_lat", 32'(cyc - e.gc), 32'(1 + RDL));
                end
            end
        end
        prev_busy = busy;
    end

    function automatic logic pending();
        logic p = (exp_q.size() != 0) || busy;
        for (int i = 0; i < NREQ; i++)
            p = p || (head[i] != tail[i]) || drv_req[i] || pend[i];
        return p;
    endfunction

    task automatic drain(input string tag, input int lim);
        int n = 0;
        while (pending() && n < lim) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk(tag, 32'(n < lim), 1);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {4'b0, gnt, rsp_valid, rsp_id, rsp_rdata, busy,
                  mem_addr, mem_data_in, mem_read, mem_write}, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 chk_zero("reset_outputs");
        reset = 1'b0;
        @(negedge clk);
    endtask

    int b;
    int n;

    initial begin
        repeat (3) @(posedge clk);
        #2 chk_zero("por_outputs");
        reset = 1'b0;

        // write then read-back from the other requester
        @(negedge clk);
        push_op(0, 1'b1, 5'h03, 8'hA5);
        drain("t1_wr_drain", 50);
        @(negedge clk);
        b = rlog.size();
        push_op(1, 1'b0, 5'h03, 8'h00);
        drain("t1_rd_drain", 50);
        chk("t1_rsp_cnt", 32'(rlog.size()), 32'(b + 1));
        if (rlog.size() == b + 1) chk("t1_rdata", 32'(rlog[b]), 32'h A5);

        // simultaneous reads alternate after reset
        do_reset();
        b = glog_id.size();
        push_op(0, 1'b0, 5'h03, 8'h00);
        push_op(0, 1'b0, 5'h04, 8'h00);
        push_op(1, 1'b0, 5'h05, 8'h00);
        push_op(1, 1'b0, 5'h06, 8'h00);
        drain("t2_drain", 100);
        chk("t2_count", 32'(glog_id.size()), 32'(b + 4));
        if (glog_id.size() >= b + 4) begin
            chk("t2_ord0", 32'(glog_id[b]), 0);
            chk("t2_ord1", 32'(glog_id[b + 1]), 1);
            chk("t2_ord2", 32'(glog_id[b + 2]), 0);
            chk("t2_ord3", 32'(glog_id[b + 3]), 1);
        end

        // top and bottom addresses, all-ones and all-zeros data
        @(negedge clk);
        b = rlog.size();
        push_op(0, 1'b1, 5'h1F, 8'hFF);
        push_op(0, 1'b1, 5'h00, 8'h77);
        push_op(0, 1'b1, 5'h00, 8'h00);
        push_op(0, 1'b0, 5'h1F, 8'h00);
        push_op(0, 1'b0, 5'h00, 8'h00);
        drain("t3_drain", 100);
        chk("t3_rsp_cnt", 32'(rlog.size()), 32'(b + 2));
        if (rlog.size() == b + 2) begin
            chk("t3_rd_1f", 32'(rlog[b]), 32'h FF);
            chk("t3_rd_00", 32'(rlog[b + 1]), 32'h 00);
        end

        // reset while a read from requester 0 sits in RDWAIT
        @(negedge clk);
        push_op(0, 1'b0, 5'h1F, 8'h00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[0] && n < 50);
        chk("t4_gnt_seen", 32'(gnt[0]), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 chk_zero("t4_abort_outputs");
        reset = 1'b0;
        @(negedge clk);
        chk("t4_no_rsp", 32'(rsp_valid), 0);
        b = glog_id.size();
        push_op(1, 1'b0, 5'h03, 8'h00);
        push_op(0, 1'b0, 5'h03, 8'h00);
        drain("t4_drain", 100);
        if (glog_id.size() > b) chk("t4_first_gnt", 32'(glog_id[b]), 0);
        else chk("t4_first_gnt_seen", 0, 1);

        // writes from requester 1 wait behind a read, then go back-to-back
        @(negedge clk);
        b = glog_id.size();
        push_op(0, 1'b0, 5'h07, 8'h00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[0] && n < 50);
        push_op(1, 1'b1, 5'h08, 8'h11);
        push_op(1, 1'b1, 5'h09, 8'h22);
        push_op(1, 1'b1, 5'h0A, 8'h33);
        drain("t5_drain", 100);
        chk("t5_count", 32'(glog_id.size()), 32'(b + 4));
        if (glog_id.size() >= b + 4) begin
            chk("t5_id", 32'(glog_id[b + 1]), 1);
            chk("t5_wait", 32'(glog_cyc[b + 1] - glog_cyc[b]), 32'(2 + RDL));
            chk("t5_b2b1", 32'(glog_cyc[b + 2] - glog_cyc[b + 1]), 2);
            chk("t5_b2b2", 32'(glog_cyc[b + 3] - glog_cyc[b + 2]), 2);
        end

        // random mixed traffic from both requesters
        @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            push_op(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                    DW'($urandom_range(0, 255)));
            push_op(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                    DW'($urandom_range(0, 255)));
        end
        drain("t6_drain", 3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
